// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: assigns batched transactions to the lowest free execution lane and enforces a drain barrier between batches.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axis_*                    incoming transaction stream (read set is ignored)
//   batch_completed             pulse closing the current batch
//   lane_start, lane_programID  one-hot dispatch pulse and the dispatched program ID
//   lane_done                   per-lane completion pulses
//   lanes_busy                  lane occupancy bitmap
//   active_write_mask           union of write sets held by busy lanes
//   dispatched_count            transactions dispatched
//   batches_retired             completed barriers
//   done_error                  sticky flag for a completion on an idle lane
module dispatch_scheduler #(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_LANES        = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [63:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    input  logic                        batch_completed,
    output logic [NUM_LANES-1:0]        lane_start,
    output logic [63:0]                 lane_programID,
    input  logic [NUM_LANES-1:0]        lane_done,
    output logic [NUM_LANES-1:0]        lanes_busy,
    output logic [MAX_DEPENDENCIES-1:0] active_write_mask,
    output logic [31:0]                 dispatched_count,
    output logic [31:0]                 batches_retired,
    output logic                        done_error
);
    typedef enum logic {DISPATCH, DRAIN} state_t;
    state_t state, state_nx;
    logic barrier_pending, pending_nx;
    logic [NUM_LANES-1:0] free_lanes, grant;
    logic [MAX_DEPENDENCIES-1:0] lane_mask [NUM_LANES];
    logic accept, retire;
    logic unused_read_deps;
    assign unused_read_deps = ^s_axis_tdata_read_dependencies;
    assign free_lanes = ~lanes_busy;
    // isolate the lowest set bit of the free map
    assign grant = free_lanes & (~free_lanes + NUM_LANES'(1));
    assign s_axis_tready = (state == DISPATCH) && !barrier_pending && !(&lanes_busy);
    assign accept = s_axis_tvalid && s_axis_tready;
    assign retire = (state == DRAIN) && (lanes_busy == '0);
    always_comb begin
        state_nx   = state;
        pending_nx = barrier_pending;
        if (state == DISPATCH) begin
            if (barrier_pending) begin
                state_nx   = DRAIN;
                pending_nx = 1'b0;
            end else if (batch_completed) begin
                pending_nx = 1'b1;
            end
        end else if (retire) begin
            state_nx = DISPATCH;
        end
    end
    always_comb begin
        active_write_mask = '0;
        for (int i = 0; i < NUM_LANES; i++)
            active_write_mask = active_write_mask | (lanes_busy[i] ? lane_mask[i] : '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DISPATCH;
            barrier_pending <= 1'b0;
        end else begin
            state           <= state_nx;
            barrier_pending <= pending_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_busy       <= '0;
            lane_start       <= '0;
            lane_programID   <= '0;
            dispatched_count <= '0;
            batches_retired  <= '0;
            done_error       <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) lane_mask[i] <= '0;
        end else begin
            // grant only targets idle lanes, so it never collides with a done on the same lane
            lanes_busy <= (lanes_busy & ~lane_done) | (accept ? grant : '0);
            lane_start <= accept ? grant : '0;
            if (accept) begin
                lane_programID   <= s_axis_tdata_owner_programID;
                dispatched_count <= dispatched_count + 32'd1;
            end
            if (retire) batches_retired <= batches_retired + 32'd1;
            if (|(lane_done & ~lanes_busy)) done_error <= 1'b1;
            for (int i = 0; i < NUM_LANES; i++)
                if (accept && grant[i]) lane_mask[i] <= s_axis_tdata_write_dependencies;
        end
    end
endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb_dispatch_scheduler: directed and random checks of dispatch_scheduler against a behavioural lane model.
module tb_dispatch_scheduler;
    localparam int MD = 256;
    localparam int NL = 4;
    logic clk = 0, rst_n = 0;
    logic s_axis_tvalid = 0, batch_completed = 0;
    logic s_axis_tready;
    logic [63:0] pid_in = '0, lane_programID;
    logic [MD-1:0] rd_in = '0, wd_in = '0, active_write_mask;
    logic [NL-1:0] lane_start, lane_done = '0, lanes_busy;
    logic [31:0] dispatched_count, batches_retired;
    logic done_error;
    int compared = 0, mismatched = 0;
    bit m_busy [NL];
    logic [MD-1:0] m_mask [NL];
    logic [NL-1:0] m_start;
    logic [63:0] m_pid;
    int unsigned m_cnt, m_ret;
    bit m_err;
    int m_phase;
    dispatch_scheduler #(.MAX_DEPENDENCIES(MD), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata_owner_programID(pid_in),
        .s_axis_tdata_read_dependencies(rd_in),
        .s_axis_tdata_write_dependencies(wd_in),
        .batch_completed(batch_completed),
        .lane_start(lane_start), .lane_programID(lane_programID),
        .lane_done(lane_done), .lanes_busy(lanes_busy),
        .active_write_mask(active_write_mask),
        .dispatched_count(dispatched_count), .batches_retired(batches_retired),
        .done_error(done_error));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [MD-1:0] obs, input logic [MD-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [MD-1:0] rand256();
        logic [MD-1:0] r;
        for (int i = 0; i < MD / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_busy[i] = 0;
            m_mask[i] = '0;
        end
        m_start = '0; m_pid = '0; m_cnt = 0; m_ret = 0; m_err = 0; m_phase = 0;
    endtask
    // phase 0: accepting, 1: batch just closed, 2: waiting for lanes to empty
    function automatic bit m_tready();
        bit any_free = 0;
        for (int i = 0; i < NL; i++) if (!m_busy[i]) any_free = 1;
        return m_phase == 0 && any_free;
    endfunction
    function automatic logic [NL-1:0] m_busy_vec();
        logic [NL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = m_busy[i];
        return v;
    endfunction
    function automatic logic [MD-1:0] m_awm();
        logic [MD-1:0] a = '0;
        for (int i = 0; i < NL; i++) if (m_busy[i]) a |= m_mask[i];
        return a;
    endfunction
    task automatic check_all(input string tag);
        chk({tag, ".tready"}, s_axis_tready, m_tready());
        chk({tag, ".start"}, lane_start, m_start);
        chk({tag, ".busy"}, lanes_busy, m_busy_vec());
        chk({tag, ".awm"}, active_write_mask, m_awm());
        chk({tag, ".cnt"}, dispatched_count, m_cnt);
        chk({tag, ".ret"}, batches_retired, m_ret);
        chk({tag, ".err"}, done_error, m_err);
        if (m_start != '0) chk({tag, ".pid"}, lane_programID, m_pid);
    endtask
    task automatic check_reset(input string tag);
        chk({tag, ".start"}, lane_start, 0);
        chk({tag, ".pid"}, lane_programID, 0);
        chk({tag, ".busy"}, lanes_busy, 0);
        chk({tag, ".awm"}, active_write_mask, 0);
        chk({tag, ".cnt"}, dispatched_count, 0);
        chk({tag, ".ret"}, batches_retired, 0);
        chk({tag, ".err"}, done_error, 0);
    endtask
    // check current outputs, then advance one clock and update the model from the applied inputs
    task automatic step(input string tag);
        bit tr, none_busy;
        int k;
        check_all(tag);
        tr = m_tready();
        none_busy = (m_busy_vec() == '0);
        @(posedge clk);
        k = -1;
        for (int i = NL - 1; i >= 0; i--) if (!m_busy[i]) k = i;
        m_start = '0;
        for (int i = 0; i < NL; i++)
            if (lane_done[i]) begin
                if (m_busy[i]) m_busy[i] = 0;
                else m_err = 1;
            end
        if (s_axis_tvalid && tr) begin
            m_busy[k] = 1;
            m_mask[k] = wd_in;
            m_start[k] = 1'b1;
            m_pid = pid_in;
            m_cnt++;
        end
        if (m_phase == 0 && batch_completed) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && none_busy) begin
            m_phase = 0;
            m_ret++;
        end
        @(negedge clk);
        batch_completed = 0;
        lane_done = '0;
    endtask
    initial begin
        model_reset();
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1;
            pid_in = 64'h10 + 64'(i);
            wd_in = rand256();
            rd_in = rand256();
            step("fill");
        end
        pid_in = 64'h14;
        chk("full.tready", s_axis_tready, 0);
        chk("full.start", lane_start, 4'b1000);
        chk("full.cnt", dispatched_count, 4);
        lane_done = 4'b0100;
        step("done2");
        chk("done2.busy", lanes_busy, 4'b1011);
        step("realloc");
        chk("realloc.start", lane_start, 4'b0100);
        chk("realloc.pid", lane_programID, 64'h14);
        s_axis_tvalid = 0;
        lane_done = 4'b1111;
        step("drain_all");
        step("idle");
        s_axis_tvalid = 1;
        pid_in = 64'h20; wd_in = 256'h1;
        step("wr1");
        pid_in = 64'h21; wd_in = 256'h2;
        step("wr2");
        s_axis_tvalid = 0;
        step("wr_hold");
        chk("awm3", active_write_mask, 256'h3);
        lane_done = 4'b0001;
        step("wr_done0");
        chk("awm2", active_write_mask, 256'h2);
        s_axis_tvalid = 1;
        pid_in = 64'h30; wd_in = 256'h4;
        batch_completed = 1;
        step("bc_acc");
        s_axis_tvalid = 0;
        chk("bc_acc.start", lane_start, 4'b0001);
        step("bc_wait1");
        step("bc_wait2");
        lane_done = 4'b0011;
        step("bc_done");
        chk("bc_done.tready", s_axis_tready, 0);
        step("bc_retire");
        chk("bc.ret", batches_retired, 1);
        chk("bc.tready", s_axis_tready, 1);
        batch_completed = 1;
        step("bc_idle");
        chk("bc_idle.t1", s_axis_tready, 0);
        step("bc_idle1");
        chk("bc_idle.t2", s_axis_tready, 0);
        step("bc_idle2");
        chk("bc_idle.t3", s_axis_tready, 1);
        chk("bc_idle.ret", batches_retired, 2);
        lane_done = 4'b0001;
        step("err");
        chk("err.set", done_error, 1);
        step("err_hold");
        chk("err.sticky", done_error, 1);
        for (int n = 0; n < 400; n++) begin
            s_axis_tvalid = $urandom_range(0, 3) != 0;
            pid_in = {$urandom, $urandom};
            wd_in = rand256();
            rd_in = rand256();
            batch_completed = $urandom_range(0, 19) == 0;
            for (int i = 0; i < NL; i++) lane_done[i] = m_busy[i] && ($urandom_range(0, 3) == 0);
            step("rnd");
        end
        s_axis_tvalid = 1;
        wd_in = rand256();
        step("pre_rst");
        #2 rst_n = 0;
        #1 check_reset("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        s_axis_tvalid = 0;
        step("post_rst");
        lane_done = 4'b0001;
        step("post_rst_done");
        chk("post_rst.err", done_error, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
